rmw_write_unit: RTL and testbench
=================================

RMW_WRITE_UNIT -- requirements
Module: rmw_write_unit

Interface
REQ-001 Parameter DATA_W, default 32, memory word width in bits; legal values are 32 and 64.
REQ-002 Parameter ADDR_W, default 32, byte address width; mem_addr width is WA = ADDR_W - log2(DATA_W/8).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_valid/req_ready  input/output  1/1  request handshake; transfer when both high at a rising edge.
REQ-006 req_we  input  1  0 read, 1 write.
REQ-007 req_size  input  2  0 byte, 1 halfword, 2 word(32), 3 doubleword (legal only if DATA_W=64).
REQ-008 req_addr, req_wdata  input  ADDR_W, DATA_W  byte address; write data, right-aligned.
REQ-009 rsp_valid/rsp_ready  output/input  1/1  response handshake.
REQ-010 rsp_rdata, rsp_err  output  DATA_W, 1  right-aligned zero-extended read data; error flag.
REQ-011 mem_cs, mem_we  output  1, 1  memory select and write strobe, registered.
REQ-012 mem_addr, mem_wdata, mem_be  output  WA, DATA_W, DATA_W/8  word address, word data, byte enables, registered.
REQ-013 mem_rdata  input  DATA_W  valid the cycle after a read cycle (mem_cs=1, mem_we=0).

Function
REQ-014 Big-endian lanes: byte offset 0 in a word maps to the most significant byte.
REQ-015 FSM states: IDLE, READ, CAPTURE, WRITE, RESP; req_ready=1 only in IDLE.
REQ-016 Misaligned request (halfword with addr[0]=1, word with addr[1:0]!=0, doubleword with addr[2:0]!=0, or size 3 with DATA_W=32): IDLE->RESP, rsp_err=1, no memory cycle.
REQ-017 Full-width write (size = DATA_W): IDLE->WRITE->RESP; rsp_valid in the 2nd cycle after acceptance.
REQ-018 Read of any size: IDLE->READ->CAPTURE->RESP; CAPTURE latches mem_rdata; rsp_valid in the 3rd cycle.
REQ-019 Sub-word write: IDLE->READ->CAPTURE->WRITE->RESP; CAPTURE merges the shifted req_wdata lanes into the captured word; rsp_valid in the 4th cycle.
REQ-020 mem_cs=1 only in READ and WRITE; mem_we=1 only in WRITE; mem_be is all ones unless REQ-029 applies.
REQ-021 RESP holds rsp_valid and rsp_rdata stable until rsp_ready=1, then returns to IDLE; the next request is accepted no earlier than the following edge.
REQ-022 Request address and data are latched at acceptance; later changes on req_* are ignored.
REQ-023 Write responses return rsp_rdata=0; rsp_err=0 for every legal request.

Reset
REQ-024 rst=1 forces IDLE immediately, regardless of clk.
REQ-025 While rst=1: mem_cs=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, req_ready=0.
REQ-026 After rst deasserts: req_ready=1 on the first rising edge.
REQ-027 Reset during READ, CAPTURE or WRITE abandons the operation; no partial write is issued after release.

Configuration
REQ-028 Macro RMW_MEM_BE_EN selects byte-enable memory support.
REQ-029 With RMW_MEM_BE_EN defined: sub-word writes take IDLE->WRITE->RESP; mem_be marks the addressed lanes and mem_wdata carries the data replicated into those lanes.
REQ-030 Without RMW_MEM_BE_EN: sub-word writes use read-modify-write per REQ-019, and mem_be is tied to all ones whenever mem_cs=1.

Verification
REQ-031 Reset: assert rst mid-cycle -> all outputs zero in the same cycle; req_ready=1 at the first edge after release.
REQ-032 Byte write: word 1 = 0x11223344; write byte 0xAB to addr 0x5 -> read cycle on word 1, then write 0x11AB3344; rsp_valid 4 cycles after acceptance (RMW build).
REQ-033 Halfword read at addr 0x6 of 0x11AB3344 -> rsp_rdata=0x00003344, rsp_err=0, 3-cycle latency.
REQ-034 Halfword write at addr 0x3 -> rsp_err=1 one cycle after acceptance; mem_cs stays 0.
REQ-035 Backpressure: rsp_ready=0 for 3 cycles in RESP -> rsp_valid/rsp_rdata held and req_ready=0 throughout; IDLE on the edge where rsp_ready=1.
REQ-036 RMW_MEM_BE_EN build, byte 0xAB to addr 0x5 -> single write with mem_be=4'b0100 and mem_wdata=0xABABABAB; rsp_valid 2 cycles after acceptance.

Source files
------------

// File: rtl/rmw_write_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rmw_write_unit                                               |
// | Description : Big-endian sub-word access unit in front of a word memory.   |
// |               It uses read-modify-write, or byte enables when              |
// |               RMW_MEM_BE_EN is defined.                                    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module rmw_write_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                req_valid,
  output logic                                req_ready,
  input  logic                                req_we,
  input  logic [1:0]                          req_size,
  input  logic [ADDR_W-1:0]                   req_addr,
  input  logic [DATA_W-1:0]                   req_wdata,
  output logic                                rsp_valid,
  input  logic                                rsp_ready,
  output logic [DATA_W-1:0]                   rsp_rdata,
  output logic                                rsp_err,
  output logic                                mem_cs,
  output logic                                mem_we,
  output logic [ADDR_W-$clog2(DATA_W/8)-1:0]  mem_addr,
  output logic [DATA_W-1:0]                   mem_wdata,
  output logic [DATA_W/8-1:0]                 mem_be,
  input  logic [DATA_W-1:0]                   mem_rdata
);

  localparam int NB = DATA_W / 8;
  localparam int OB = $clog2(NB);
  localparam logic [NB-1:0] c_be_ones = '1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_CAPTURE = 3'd2,
    S_WRITE   = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_we;
  logic [1:0]        r_size;
  logic [OB-1:0]     r_off;
  logic [DATA_W-1:0] r_wdata;

  logic              w_accept;
  logic              w_misal;
  logic              w_full;
  logic              w_mem_go;
  logic [DATA_W-1:0] w_mem_wdata;
  logic [NB-1:0]     w_mem_be;
  logic [DATA_W-1:0] w_rsp_rdata;
  logic              w_rsp_err;

  // Offset 0 is the most significant byte, so a field of n bytes at offset o
  // sits DATA_W - 8*(o+n) bits above bit 0.
  function automatic int f_shift(input logic [1:0] size, input logic [OB-1:0] off);
    return DATA_W - 8 * (int'(off) + (1 << size));
  endfunction

  function automatic logic [DATA_W-1:0] f_field_mask(input logic [1:0] size);
    logic [DATA_W-1:0] ones;
    ones = '1;
    return ones >> (DATA_W - (8 << size));
  endfunction

  function automatic logic [DATA_W-1:0] f_extract(input logic [DATA_W-1:0] word,
                                                  input logic [1:0] size,
                                                  input logic [OB-1:0] off);
    return (word >> f_shift(size, off)) & f_field_mask(size);
  endfunction

  function automatic logic [DATA_W-1:0] f_merge(input logic [DATA_W-1:0] word,
                                                input logic [DATA_W-1:0] data,
                                                input logic [1:0] size,
                                                input logic [OB-1:0] off);
    logic [DATA_W-1:0] m;
    m = f_field_mask(size) << f_shift(size, off);
    return (word & ~m) | ((data << f_shift(size, off)) & m);
  endfunction

`ifdef RMW_MEM_BE_EN
  function automatic logic [NB-1:0] f_lane_be(input logic [1:0] size, input logic [OB-1:0] off);
    logic [NB-1:0] ones;
    ones = '1;
    return (ones >> (NB - (1 << size))) << (NB - int'(off) - (1 << size));
  endfunction

  function automatic logic [DATA_W-1:0] f_replicate(input logic [DATA_W-1:0] d,
                                                    input logic [1:0] size);
    logic [DATA_W-1:0] rep;
    rep = '0;
    for (int i = 0; i < NB; i++) rep[8*i +: 8] = d[8*(i % (1 << size)) +: 8];
    return rep;
  endfunction
`endif

  assign w_accept = req_valid & req_ready;
  assign w_full   = ((8 << req_size) == DATA_W);
  assign w_mem_go = (w_next == S_READ) || (w_next == S_WRITE);

  always_comb begin
    w_misal = 1'b0;
    unique case (req_size)
      2'd0:    w_misal = 1'b0;
      2'd1:    w_misal = req_addr[0];
      2'd2:    w_misal = |req_addr[1:0];
      default: w_misal = (DATA_W == 32) || (|req_addr[2:0]);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_mem_wdata = mem_wdata;
    w_mem_be    = c_be_ones;
    w_rsp_rdata = rsp_rdata;
    w_rsp_err   = rsp_err;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_misal) begin
            w_next      = S_RESP;
            w_rsp_err   = 1'b1;
            w_rsp_rdata = '0;
          end else if (!req_we) begin
            w_next = S_READ;
          end else if (w_full) begin
            w_next      = S_WRITE;
            w_mem_wdata = req_wdata;
          end else begin
`ifdef RMW_MEM_BE_EN
            w_next      = S_WRITE;
            w_mem_wdata = f_replicate(req_wdata, req_size);
            w_mem_be    = f_lane_be(req_size, req_addr[OB-1:0]);
`else
            w_next = S_READ;
`endif
          end
        end
      end
      S_READ: w_next = S_CAPTURE;
      S_CAPTURE: begin
        if (r_we) begin
          w_next      = S_WRITE;
          w_mem_wdata = f_merge(mem_rdata, r_wdata, r_size, r_off);
        end else begin
          w_next      = S_RESP;
          w_rsp_err   = 1'b0;
          w_rsp_rdata = f_extract(mem_rdata, r_size, r_off);
        end
      end
      S_WRITE: begin
        w_next      = S_RESP;
        w_rsp_err   = 1'b0;
        w_rsp_rdata = '0;
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_next      = S_IDLE;
          w_rsp_err   = 1'b0;
          w_rsp_rdata = '0;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Every output is a flop loaded from the next-state decode, so the memory
  // and response strobes line up exactly with the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      mem_cs    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      r_we      <= 1'b0;
      r_size    <= '0;
      r_off     <= '0;
      r_wdata   <= '0;
    end else begin
      req_ready <= (w_next == S_IDLE);
      rsp_valid <= (w_next == S_RESP);
      rsp_rdata <= w_rsp_rdata;
      rsp_err   <= w_rsp_err;
      mem_cs    <= w_mem_go;
      mem_we    <= (w_next == S_WRITE);
      mem_wdata <= w_mem_wdata;
      mem_be    <= w_mem_go ? w_mem_be : '0;
      if (w_accept) begin
        r_we     <= req_we;
        r_size   <= req_size;
        r_off    <= req_addr[OB-1:0];
        r_wdata  <= req_wdata;
        mem_addr <= req_addr[ADDR_W-1:OB];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rmw_write_unit.sv
`default_nettype none
// Bench for rmw_write_unit: byte-array reference memory, response scoreboard
// and directed requests. Works for both the RMW and the RMW_MEM_BE_EN build.
module tb_rmw_write_unit;
  localparam int DW = 32;
  localparam int AW = 32;
`ifdef RMW_MEM_BE_EN
  localparam bit BE = 1'b1;
`else
  localparam bit BE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid, req_ready, req_we;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_cs, mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  rmw_write_unit #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  // Memory attached to the DUT, and the byte-level reference image.
  logic [31:0] bmem [16];
  logic [7:0]  refb [64];
  int          ncs = 0;
  int          nwr = 0;
  logic [31:0] last_wd;
  logic [3:0]  last_be;

  always @(posedge clk) begin
    if (mem_cs) begin
      ncs++;
      if (mem_we) begin
        nwr++;
        last_wd = mem_wdata;
        last_be = mem_be;
        for (int i = 0; i < 4; i++)
          if (mem_be[i]) bmem[mem_addr[3:0]][8*i +: 8] = mem_wdata[8*i +: 8];
      end else begin
        mem_rdata <= bmem[mem_addr[3:0]];
      end
    end
  end

  function automatic logic [31:0] ref_word(input int w);
    return {refb[4*w], refb[4*w+1], refb[4*w+2], refb[4*w+3]};
  endfunction

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        expq[$];
  exp_t        cur;
  bit          in_rsp = 1'b0;
  logic [29:0] cur_waddr = '0;
  logic [31:0] last_rdata;
  logic        last_err;
  int          last_lat;

  // Scoreboard: checks every cycle the response or memory port is active.
  always @(negedge clk) begin
    if (rst) begin
      in_rsp = 1'b0;
    end else begin
      if (mem_cs) begin
        check("mem_addr", mem_addr, cur_waddr);
        if (!BE) check("mem_be_all_ones", mem_be, 4'hF);
      end
      if (rsp_valid) begin
        check("ready_low_in_resp", req_ready, 1'b0);
        if (!in_rsp) begin
          if (expq.size() == 0) begin
            fail_now("unexpected_rsp");
          end else begin
            cur = expq.pop_front();
            last_rdata = rsp_rdata;
            last_err   = rsp_err;
            last_lat   = cyc - cur.acc;
            check("rsp_rdata", rsp_rdata, cur.rdata);
            check("rsp_err", rsp_err, cur.err);
            check("rsp_latency", last_lat, cur.lat);
          end
          in_rsp = 1'b1;
        end else begin
          check("rsp_rdata_held", rsp_rdata, cur.rdata);
          check("rsp_err_held", rsp_err, cur.err);
        end
      end else begin
        in_rsp = 1'b0;
      end
    end
  end

  task automatic do_req(input logic we, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, input int hold);
    exp_t e;
    int   n, k, ncs0, exp_cs;
    bit   misal;
    n       = 1 << size;
    misal   = (size == 2'd3) || (addr % n != 0);
    e.err   = misal;
    e.rdata = '0;
    if (!misal && !we)
      for (int i = 0; i < n; i++) e.rdata = (e.rdata << 8) | 32'(refb[addr+i]);
    e.lat  = misal ? 1 : (!we ? 3 : (((n == 4) || BE) ? 2 : 4));
    exp_cs = misal ? 0 : ((!we || n == 4 || BE) ? 1 : 2);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_addr = addr; req_wdata = wdata;
    rsp_ready = (hold == 0);
    k = 0;
    while (!req_ready && k < 20) begin @(negedge clk); k++; end
    if (!req_ready) begin
      fail_now("req_ready_timeout");
      req_valid = 1'b0;
      return;
    end
    e.acc     = cyc;
    cur_waddr = addr[31:2];
    ncs0      = ncs;
    expq.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_size  = 2'($urandom);
    req_we    = 1'($urandom);
    if (!misal && we)
      for (int i = 0; i < n; i++) refb[addr+i] = wdata[8*(n-1-i) +: 8];
    k = 0;
    while (!rsp_valid && k < 20) begin @(negedge clk); k++; end
    if (!rsp_valid) begin
      fail_now("rsp_valid_timeout");
      return;
    end
    repeat (hold) @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("ready_after_resp", req_ready, 1'b1);
    check("valid_drop_after_resp", rsp_valid, 1'b0);
    check("mem_cycles", ncs - ncs0, exp_cs);
    check("mem_word", bmem[addr[5:2]], ref_word(int'(addr[5:2])));
  endtask

  task automatic check_reset_zero(input string tag);
    check({tag, "_mem_cs"}, mem_cs, 1'b0);
    check({tag, "_mem_we"}, mem_we, 1'b0);
    check({tag, "_mem_addr"}, mem_addr, 30'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_mem_be"}, mem_be, 4'd0);
    check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    check({tag, "_rsp_err"}, rsp_err, 1'b0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    check({tag, "_req_ready"}, req_ready, 1'b0);
  endtask

  logic [31:0] init_v;
  logic [31:0] word0;
  int          nwr0;
  int          k;

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0;
    for (int w = 0; w < 16; w++) begin
      init_v = (w == 1) ? 32'h11223344 : (32'hA0B0C0D0 ^ (w * 32'h01030507));
      bmem[w] = init_v;
      for (int i = 0; i < 4; i++) refb[4*w+i] = init_v[31-8*i -: 8];
    end
    #2;
    check_reset_zero("por");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_release", req_ready, 1'b1);

    // Byte 0xAB into offset 1 of word 1.
    do_req(1'b1, 2'd0, 32'h5, 32'hAB, 0);
    check("byte_write_word1", bmem[1], 32'h11AB3344);
`ifdef RMW_MEM_BE_EN
    check("be_write_lanes", last_be, 4'b0100);
    check("be_write_data", last_wd, 32'hABABABAB);
    check("be_write_latency", last_lat, 2);
`else
    check("rmw_write_data", last_wd, 32'h11AB3344);
    check("rmw_write_be", last_be, 4'hF);
    check("rmw_write_latency", last_lat, 4);
`endif

    do_req(1'b0, 2'd1, 32'h6, 32'h0, 0);
    check("hw_read_data", last_rdata, 32'h00003344);
    check("hw_read_err", last_err, 1'b0);
    check("hw_read_latency", last_lat, 3);

    do_req(1'b1, 2'd1, 32'h3, 32'hBEEF, 0);
    check("misaligned_err", last_err, 1'b1);
    check("misaligned_latency", last_lat, 1);

    do_req(1'b1, 2'd2, 32'h8, 32'hDEADBEEF, 3);
    check("full_write_latency", last_lat, 2);
    do_req(1'b0, 2'd2, 32'h8, 32'h0, 3);
    check("word_read_data", last_rdata, 32'hDEADBEEF);
    do_req(1'b0, 2'd0, 32'hB, 32'h0, 0);
    check("byte_read_data", last_rdata, 32'h000000EF);
    do_req(1'b1, 2'd1, 32'hA, 32'h1234, 1);
    check("hw_write_word2", bmem[2], 32'hDEAD1234);
    do_req(1'b1, 2'd0, 32'hC, 32'h5A, 0);
    do_req(1'b1, 2'd0, 32'hF, 32'hC3, 2);
    do_req(1'b0, 2'd2, 32'hC, 32'h0, 0);
    do_req(1'b0, 2'd2, 32'h2, 32'h0, 0);
    do_req(1'b0, 2'd3, 32'h0, 32'h0, 0);
    check("size3_err", last_err, 1'b1);
    do_req(1'b1, 2'd1, 32'h11, 32'h7777, 0);
    do_req(1'b0, 2'd1, 32'h14, 32'h0, 0);

    // Reset in the middle of a sub-word write must drop it entirely.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 32'hD; req_wdata = 32'h99;
    k = 0;
    while (!req_ready && k < 20) begin @(negedge clk); k++; end
    if (!req_ready) fail_now("abort_ready_timeout");
    cur_waddr = 30'd3;
    nwr0      = nwr;
    word0     = bmem[3];
    @(posedge clk);
    #2;
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_zero("abort");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready_after_release", req_ready, 1'b1);
    repeat (4) @(negedge clk);
    check("abort_no_write", nwr, nwr0);
    check("abort_word_kept", bmem[3], word0);

    do_req(1'b0, 2'd2, 32'hC, 32'h0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
